// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage.
//
// Owns the PC, a single-outstanding-request handshake to instruction memory,
// a one-entry fetch buffer and the IF/ID register. Branch/jump targets are
// computed from the instruction held in IF/ID; the control unit decides the
// redirect through pcSrc/jORb and steers the stage with pcWrite, ifidWrite
// and ifidFlush.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pcSrc, jORb              redirect request for ID (jORb: 1=branch, 0=jump)
//   pcWrite                  0 = hold PC and block new requests
//   ifidWrite, ifidFlush     IF/ID hold / load-bubble controls
//   imemReq, imemAddr        one-cycle request pulse and its address
//   imemValid, imemData      response strobe and instruction word
//   pc                       address of the next request
//   ifidINS/PC4/Valid        IF/ID contents
//   fetchBusy                request outstanding
//   perfBubbles/Redirects    performance counters
//
// Build option: define FETCH_PERF_EN to build the performance counters;
// otherwise both perf ports read 0 and no counter logic exists.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcSrc,
  input  logic        pcWrite,
  input  logic        ifidWrite,
  input  logic        ifidFlush,
  input  logic        jORb,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] pc,
  output logic [31:0] ifidINS,
  output logic [31:0] ifidPC4,
  output logic        ifidValid,
  output logic        fetchBusy,
  output logic [31:0] perfBubbles,
  output logic [31:0] perfRedirects
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state;
  logic        squash;
  logic        buf_valid;
  logic [31:0] buf_ins;
  logic [31:0] buf_pc4;
  logic [31:0] tag_pc4;   // PC+4 of the outstanding request

  logic        redirect, resp, resp_ok, issue, bubble_load;
  logic [31:0] br_target, j_target, target;

  assign redirect  = pcSrc & ifidValid;
  assign resp      = (state == WAIT) & imemValid;
  assign resp_ok   = resp & ~squash;
  // Issue needs an empty buffer, so the buffer can never overflow.
  assign issue     = ~rst & (state == IDLE) & pcWrite & ~buf_valid & ~redirect;

  assign br_target = ifidPC4 + {{14{ifidINS[15]}}, ifidINS[15:0], 2'b00};
  assign j_target  = {ifidPC4[31:28], ifidINS[25:0], 2'b00};
  assign target    = jORb ? br_target : j_target;

  assign imemReq   = issue;
  assign imemAddr  = issue ? pc : 32'h0;
  assign fetchBusy = (state == WAIT);

  // IF/ID loads a bubble only because nothing was available to load.
  assign bubble_load = ~redirect & ~ifidFlush & ifidWrite & ~buf_valid & ~resp_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      squash    <= 1'b0;
      buf_valid <= 1'b0;
      buf_ins   <= 32'h0;
      buf_pc4   <= 32'h0;
      tag_pc4   <= 32'h0;
      pc        <= RESET_PC;
      ifidINS   <= NOP_INS;
      ifidPC4   <= 32'h0;
      ifidValid <= 1'b0;
    end else begin
      if (resp)       state <= IDLE;
      else if (issue) state <= WAIT;

      if (resp) squash <= 1'b0;

      if (issue) begin
        pc      <= pc + 32'd4;
        tag_pc4 <= pc + 32'd4;
      end

      if (redirect) begin
        // A same-cycle response is dropped simply by not using it; a
        // response still in flight is marked for dropping on arrival.
        pc        <= target;
        buf_valid <= 1'b0;
        ifidINS   <= NOP_INS;
        ifidValid <= 1'b0;
        if (state == WAIT && !imemValid) squash <= 1'b1;
      end else if (ifidFlush || !ifidWrite) begin
        if (ifidFlush) begin
          ifidINS   <= NOP_INS;
          ifidValid <= 1'b0;
        end
        if (resp_ok) begin
          buf_valid <= 1'b1;
          buf_ins   <= imemData;
          buf_pc4   <= tag_pc4;
        end
      end else if (buf_valid) begin
        ifidINS   <= buf_ins;
        ifidPC4   <= buf_pc4;
        ifidValid <= 1'b1;
        buf_valid <= resp_ok;
        if (resp_ok) begin
          buf_ins <= imemData;
          buf_pc4 <= tag_pc4;
        end
      end else if (resp_ok) begin
        ifidINS   <= imemData;
        ifidPC4   <= tag_pc4;
        ifidValid <= 1'b1;
      end else begin
        ifidINS   <= NOP_INS;
        ifidValid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubbles_q, redirects_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubbles_q   <= 32'h0;
      redirects_q <= 32'h0;
    end else begin
      if (bubble_load) bubbles_q   <= bubbles_q + 32'd1;
      if (redirect)    redirects_q <= redirects_q + 32'd1;
    end
  end

  assign perfBubbles   = bubbles_q;
  assign perfRedirects = redirects_q;
`else
  logic unused_perf;
  assign unused_perf   = bubble_load;
  assign perfBubbles   = 32'h0;
  assign perfRedirects = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The bench plays instruction memory by
// hand: every response is driven explicitly on a chosen cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BEQ  = 32'h1000_FFFE;  // imm = -2
  localparam logic [31:0] J40  = 32'h0800_0040;  // target field 26'h40
  localparam logic [31:0] J80  = 32'h0800_0080;  // target field 26'h80
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcSrc, pcWrite, ifidWrite, ifidFlush, jORb;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] pc, ifidINS, ifidPC4;
  logic        ifidValid, fetchBusy;
  logic [31:0] perfBubbles, perfRedirects;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INS(NOP)) dut (
    .clk(clk), .rst(rst),
    .pcSrc(pcSrc), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .ifidFlush(ifidFlush), .jORb(jORb),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData),
    .pc(pc), .ifidINS(ifidINS), .ifidPC4(ifidPC4), .ifidValid(ifidValid),
    .fetchBusy(fetchBusy),
    .perfBubbles(perfBubbles), .perfRedirects(perfRedirects)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic w, input logic iw,
                        input logic fl, input logic jb, input logic v,
                        input logic [31:0] d);
    pcSrc = s; pcWrite = w; ifidWrite = iw; ifidFlush = fl; jORb = jb;
    imemValid = v; imemData = d;
  endtask

  // Issue one request and answer it the next cycle; IF/ID ends holding d.
  task automatic fetch_one(input logic [31:0] d);
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    tick;
    set_in(0, 1, 1, 0, 0, 1, d);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    tick; tick;
    checks++;
    if (imemReq !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", imemReq);
    end
    checks++;
    if (pc !== 32'h0 || ifidINS !== NOP || ifidPC4 !== 32'h0 || ifidValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h ins=%h pc4=%h v=%b expected 0/0/0/0",
               pc, ifidINS, ifidPC4, ifidValid);
    end
    checks++;
    if (fetchBusy !== 1'b0 || perfBubbles !== 32'h0 || perfRedirects !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy_perf: busy=%b pb=%0d pr=%0d expected 0/0/0",
               fetchBusy, perfBubbles, perfRedirects);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] d;
      d = 32'hA000_0000 + 32'(k);
      set_in(0, 1, 1, 0, 0, 0, 32'h0);
      #1;
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_issue%0d: req=%b addr=%h expected req=1 addr=%h",
                 k, imemReq, imemAddr, 32'(4 * k));
      end
      tick;
      checks++;
      if (fetchBusy !== 1'b1 || pc !== 32'(4 * k + 4)) begin
        errors++;
        $display("FAIL stream_wait%0d: busy=%b pc=%h expected busy=1 pc=%h",
                 k, fetchBusy, pc, 32'(4 * k + 4));
      end
      set_in(0, 1, 1, 0, 0, 1, d);
      #1;
      checks++;
      if (imemReq !== 1'b0) begin
        errors++; $display("FAIL stream_noreq%0d: got %b expected 0", k, imemReq);
      end
      tick;
      checks++;
      if (ifidINS !== d || ifidPC4 !== 32'(4 * k + 4) || ifidValid !== 1'b1) begin
        errors++;
        $display("FAIL stream_ifid%0d: ins=%h pc4=%h v=%b expected %h/%h/1",
                 k, ifidINS, ifidPC4, ifidValid, d, 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_stall;
    // IF/ID holds A0000002 (pc4=12), pc=12
    set_in(0, 1, 0, 0, 0, 0, 32'h0);
    tick;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, (c == 0), (c == 0) ? 32'hB000_0003 : 32'h0);
      #1;
      checks++;
      if (imemReq !== 1'b0) begin
        errors++; $display("FAIL stall_noreq%0d: got %b expected 0", c, imemReq);
      end
      tick;
      checks++;
      if (pc !== 32'h10 || ifidINS !== 32'hA000_0002 || ifidValid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%h ins=%h v=%b expected 10/a0000002/1",
                 c, pc, ifidINS, ifidValid);
      end
    end
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (imemReq !== 1'b0) begin
      errors++; $display("FAIL stall_bufblock: req=%b expected 0", imemReq);
    end
    tick;
    checks++;
    if (ifidINS !== 32'hB000_0003 || ifidPC4 !== 32'h10 || ifidValid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: ins=%h pc4=%h v=%b expected b0000003/10/1",
               ifidINS, ifidPC4, ifidValid);
    end
  endtask

  task automatic test_branch;
    fetch_one(32'hC000_0004);
    fetch_one(32'hC000_0005);
    fetch_one(32'hC000_0006);
    fetch_one(BEQ);
    checks++;
    if (ifidINS !== BEQ || ifidPC4 !== 32'h20) begin
      errors++;
      $display("FAIL branch_setup: ins=%h pc4=%h expected %h/20", ifidINS, ifidPC4, BEQ);
    end
    set_in(1, 1, 1, 0, 1, 0, 32'h0);
    #1;
    checks++;
    if (imemReq !== 1'b0) begin
      errors++; $display("FAIL branch_noreq: got %b expected 0", imemReq);
    end
    tick;
    checks++;
    if (pc !== 32'h18 || ifidINS !== NOP || ifidValid !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect: pc=%h ins=%h v=%b expected 18/0/0",
               pc, ifidINS, ifidValid);
    end
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h18) begin
      errors++;
      $display("FAIL branch_target_req: req=%b addr=%h expected 1/18", imemReq, imemAddr);
    end
    tick;
    set_in(0, 1, 1, 0, 0, 1, 32'hC000_0007);
    tick;
    checks++;
    if (ifidINS !== 32'hC000_0007 || ifidPC4 !== 32'h1C) begin
      errors++;
      $display("FAIL branch_refill: ins=%h pc4=%h expected c0000007/1c", ifidINS, ifidPC4);
    end
  endtask

  task automatic test_jump_wait;
    fetch_one(J40);
    set_in(0, 1, 0, 0, 0, 0, 32'h0);  // issue, IF/ID keeps the jump
    tick;
    set_in(1, 1, 1, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (imemReq !== 1'b0 || fetchBusy !== 1'b1) begin
      errors++;
      $display("FAIL jump_inwait: req=%b busy=%b expected 0/1", imemReq, fetchBusy);
    end
    tick;
    checks++;
    if (pc !== 32'h100 || ifidValid !== 1'b0 || ifidINS !== NOP) begin
      errors++;
      $display("FAIL jump_redirect: pc=%h v=%b ins=%h expected 100/0/0", pc, ifidValid, ifidINS);
    end
    set_in(0, 1, 0, 0, 0, 0, 32'h0);
    tick;
    set_in(0, 1, 0, 0, 0, 1, BAD);
    tick;
    checks++;
    if (ifidINS !== NOP || ifidValid !== 1'b0 || fetchBusy !== 1'b0) begin
      errors++;
      $display("FAIL jump_squash: ins=%h v=%b busy=%b expected 0/0/0", ifidINS, ifidValid, fetchBusy);
    end
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h100) begin
      errors++;
      $display("FAIL jump_target_req: req=%b addr=%h expected 1/100", imemReq, imemAddr);
    end
    tick;
    set_in(0, 1, 1, 0, 0, 1, 32'hD000_0001);
    tick;
    checks++;
    if (ifidINS !== 32'hD000_0001 || ifidPC4 !== 32'h104 || ifidValid !== 1'b1) begin
      errors++;
      $display("FAIL jump_refill: ins=%h pc4=%h v=%b expected d0000001/104/1",
               ifidINS, ifidPC4, ifidValid);
    end
  endtask

  task automatic test_simul;
    fetch_one(J80);
    set_in(0, 1, 0, 0, 0, 0, 32'h0);
    tick;
    set_in(1, 1, 1, 0, 0, 1, BAD);
    tick;
    checks++;
    if (pc !== 32'h200 || fetchBusy !== 1'b0 || ifidValid !== 1'b0 || ifidINS !== NOP) begin
      errors++;
      $display("FAIL simul_redirect: pc=%h busy=%b v=%b ins=%h expected 200/0/0/0",
               pc, fetchBusy, ifidValid, ifidINS);
    end
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin
      errors++;
      $display("FAIL simul_next_req: req=%b addr=%h expected 1/200", imemReq, imemAddr);
    end
    tick;
    set_in(0, 1, 1, 0, 0, 1, 32'hE000_0001);
    tick;
    checks++;
    if (ifidINS !== 32'hE000_0001 || ifidPC4 !== 32'h204) begin
      errors++;
      $display("FAIL simul_refill: ins=%h pc4=%h expected e0000001/204", ifidINS, ifidPC4);
    end
  endtask

  task automatic test_flush;
    set_in(0, 0, 0, 1, 0, 0, 32'h0);
    tick;
    checks++;
    if (ifidINS !== NOP || ifidValid !== 1'b0 || pc !== 32'h204) begin
      errors++;
      $display("FAIL flush: ins=%h v=%b pc=%h expected 0/0/204", ifidINS, ifidValid, pc);
    end
  endtask

  task automatic test_reset_mid;
    set_in(0, 1, 1, 0, 0, 0, 32'h0);
    tick;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    tick;
    rst = 1'b0;
    set_in(0, 0, 1, 0, 0, 1, BAD);
    tick;
    checks++;
    if (ifidValid !== 1'b0 || ifidINS !== NOP || fetchBusy !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: v=%b ins=%h busy=%b pc=%h expected 0/0/0/0",
               ifidValid, ifidINS, fetchBusy, pc);
    end
  endtask

  task automatic test_perf;
    logic [31:0] exp_b, exp_r;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    fetch_one(J40);                    // bubble 1 on the issue cycle
    set_in(1, 1, 1, 0, 0, 0, 32'h0);   // redirect 1
    tick;
    fetch_one(J80);                    // bubble 2
    set_in(1, 1, 1, 0, 0, 0, 32'h0);   // redirect 2
    tick;
    set_in(0, 0, 1, 0, 0, 0, 32'h0);   // bubble 3
    tick;
`ifdef FETCH_PERF_EN
    exp_b = 32'd3; exp_r = 32'd2;
`else
    exp_b = 32'd0; exp_r = 32'd0;
`endif
    checks++;
    if (perfBubbles !== exp_b || perfRedirects !== exp_r) begin
      errors++;
      $display("FAIL perf_counts: bubbles=%0d redirects=%0d expected %0d/%0d",
               perfBubbles, perfRedirects, exp_b, exp_r);
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    tick;
    rst = 1'b0;
    checks++;
    if (perfBubbles !== 32'h0 || perfRedirects !== 32'h0) begin
      errors++;
      $display("FAIL perf_reset: bubbles=%0d redirects=%0d expected 0/0",
               perfBubbles, perfRedirects);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0);
    test_reset;
    test_stream;
    test_stall;
    test_branch;
    test_jump_wait;
    test_simul;
    test_flush;
    test_reset_mid;
    test_perf;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch side of the pipeline, and consumer of the control unit's fetch-steering outputs: pcSrc, pcWrite, ifidWrite, ifidFlush and jORb.
- Owns the PC, a single-outstanding-request handshake to instruction memory, a one-entry fetch buffer and the IF/ID pipeline register.
- Computes branch and jump targets from the instruction currently held in IF/ID.
- Drives ifidINS back into the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INS, 32'h0000_0000, word loaded into IF/ID as a bubble.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pcSrc  input  1  redirect request for the instruction in ID.
- pcWrite  input  1  0 = hold PC and block new requests (load-use stall).
- ifidWrite  input  1  0 = hold IF/ID.
- ifidFlush  input  1  1 = load bubble into IF/ID.
- jORb  input  1  redirect kind: 1 = branch, 0 = jump.
- imemReq  output  1  one-cycle request pulse to instruction memory.
- imemAddr  output  32  request address, valid with imemReq.
- imemValid  input  1  response strobe; arrives at least 1 cycle after imemReq.
- imemData  input  32  instruction word, valid with imemValid.
- pc  output  32  address of the next request.
- ifidINS  output  32  IF/ID instruction, feeds control unit INS.
- ifidPC4  output  32  IF/ID PC+4.
- ifidValid  output  1  IF/ID holds a real instruction.
- fetchBusy  output  1  request outstanding.
- perfBubbles  output  32  bubble counter, see Optional Feature.
- perfRedirects  output  32  redirect counter, see Optional Feature.

Behaviour:
- Reset values:
  - pc=RESET_PC, ifidINS=NOP_INS, ifidPC4=0, ifidValid=0.
  - imemReq=0, imemAddr=0, fetchBusy=0.
  - FSM=IDLE, buffer empty, squash=0, perf counters=0.
  - Reset mid-request: the later response is ignored, because squash is cleared and the FSM is IDLE.
- FSM states:
  - IDLE: no outstanding request.
  - WAIT: request outstanding; fetchBusy=1.
- Request issue:
  - Condition: IDLE, pcWrite=1, buffer empty, no redirect this cycle.
  - Action: imemReq=1 for exactly one cycle with imemAddr=pc; tag PC4=pc+4; pc<=pc+4; go to WAIT.
- Response handling:
  - In WAIT, imemValid=1 with squash=0: the word goes straight into IF/ID if IF/ID loads this cycle, otherwise into the buffer.
  - Either way, return to IDLE.
  - A squashed response is dropped; squash<=0; return to IDLE.
- Target computation:
  - Branch target = ifidPC4 + {{14{ifidINS[15]}}, ifidINS[15:0], 2'b00}.
  - Jump target = {ifidPC4[31:28], ifidINS[25:0], 2'b00}.
  - jORb selects between them. Arithmetic is mod 2^32.
- Priority each cycle, highest first:
  1. rst.
  2. Redirect, when pcSrc=1 and ifidValid=1:
     - pc<=target; buffer cleared.
     - IF/ID<=bubble (ifidINS=NOP_INS, ifidValid=0), whatever ifidWrite/ifidFlush say.
     - If in WAIT without imemValid this cycle: squash<=1.
     - If imemValid arrives this same cycle: the word is dropped and the FSM goes to IDLE.
     - No new request is issued this cycle.
  3. ifidFlush=1 without a redirect: IF/ID<=bubble; buffer and pc are unaffected.
  4. ifidWrite=0: IF/ID holds; a response still fills the buffer.
  5. ifidWrite=1: IF/ID loads, taking the first available of:
     - the buffer (buffer then empties);
     - a same-cycle unsquashed response (bypass);
     - otherwise a bubble.
- pcSrc is ignored when ifidValid=0.
- pcWrite=0 holds pc and blocks issue only; an outstanding response still completes.
- The buffer never overflows, because issue requires the buffer to be empty.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perfBubbles increments on every cycle IF/ID loads a bubble because no instruction was available (case 5).
  - perfRedirects increments on every accepted redirect.
  - Both are 32-bit, wrap at 2^32, and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, then imemValid 1 cycle after each imemReq with ifidWrite=1: addresses 0,4,8 are issued; ifidINS follows the data with ifidPC4 = 4,8,12; ifidValid=1 from the first load onward.
- Stall: pcWrite=0 and ifidWrite=0 for 3 cycles with a response arriving: the response lands in the buffer; pc and IF/ID hold; no imemReq; on release the buffered word enters IF/ID next cycle.
- Branch redirect: ifidINS=BEQ with imm=16'hFFFE and ifidPC4=32'h20, pcSrc=1, jORb=1: pc becomes 32'h18, IF/ID gets a bubble, and the next imemAddr is 32'h18.
- Jump during WAIT: ifidINS=J with target field 26'h40, pcSrc=1, jORb=0, response arriving 2 cycles later: that response is dropped; the next request goes to 32'h100; exactly one bubble is inserted.
- Simultaneous redirect and imemValid in the same cycle: the word is discarded, the FSM is IDLE, and the next cycle issues to the target.
- FETCH_PERF_EN defined, with 3 bubble loads and 2 redirects: perfBubbles=3 and perfRedirects=2; rst clears both to 0.
